// File: rtl/ps2_key_pkg.sv
// Shared constants and lookup functions for the PS/2 key display.
// Latency: none; the functions are purely combinational.
// Backpressure: none; this package holds no state or flow control.
package ps2_key_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Hex nibble to active-low segments, bit0=a .. bit6=g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Set-2 scan code to lowercase ASCII; unmapped codes give 0x00.
  function automatic logic [7:0] scan_to_ascii(input logic [7:0] sc);
    logic [7:0] asc;
    case (sc)
      8'h1C: asc = 8'h61;  8'h32: asc = 8'h62;  8'h21: asc = 8'h63;
      8'h23: asc = 8'h64;  8'h24: asc = 8'h65;  8'h2B: asc = 8'h66;
      8'h34: asc = 8'h67;  8'h33: asc = 8'h68;  8'h43: asc = 8'h69;
      8'h3B: asc = 8'h6A;  8'h42: asc = 8'h6B;  8'h4B: asc = 8'h6C;
      8'h3A: asc = 8'h6D;  8'h31: asc = 8'h6E;  8'h44: asc = 8'h6F;
      8'h4D: asc = 8'h70;  8'h15: asc = 8'h71;  8'h2D: asc = 8'h72;
      8'h1B: asc = 8'h73;  8'h2C: asc = 8'h74;  8'h3C: asc = 8'h75;
      8'h2A: asc = 8'h76;  8'h1D: asc = 8'h77;  8'h22: asc = 8'h78;
      8'h35: asc = 8'h79;  8'h1A: asc = 8'h7A;
      8'h45: asc = 8'h30;  8'h16: asc = 8'h31;  8'h1E: asc = 8'h32;
      8'h26: asc = 8'h33;  8'h25: asc = 8'h34;  8'h2E: asc = 8'h35;
      8'h36: asc = 8'h36;  8'h3D: asc = 8'h37;  8'h3E: asc = 8'h38;
      8'h46: asc = 8'h39;
      8'h29: asc = 8'h20;  8'h5A: asc = 8'h0D;
      default: asc = 8'h00;
    endcase
    return asc;
  endfunction

endpackage

// File: rtl/seg7_hex.sv
// One hex digit on an active-low 7-segment display, blanked when disabled.
// Latency: combinational.
// Backpressure: none.
module seg7_hex
  import ps2_key_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       en,
  output logic [6:0] seg
);

  // Blank the digit unless enabled.
  always_comb begin
    seg = SEG_BLANK;
    if (en) seg = hex_to_seg(nib);
  end

endmodule

// File: rtl/ps2_key_display.sv
// PS/2 set-2 receiver with make/break tracking, ASCII lookup, press count and hex display.
// Latency: key registers update 1 clock after the stop-bit falling edge is seen post-synchroniser.
// Backpressure: none; the keyboard cannot be stalled, bad frames are dropped silently.
module ps2_key_display
  import ps2_key_pkg::*;
#(
  parameter int SYNC_STAGES = 3  // must be at least 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [6:0] io_seg1,
  output logic [6:0] io_seg2,
  output logic [6:0] io_seg3,
  output logic [6:0] io_seg4,
  output logic [6:0] io_seg5,
  output logic [6:0] io_seg6,
  output logic [7:0] scan_code,
  output logic [7:0] ascii_code,
  output logic [7:0] press_count,
  output logic       key_active
);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_fall;
  logic                   bit_in;
  logic [3:0]             bit_cnt;
  logic [9:0]             shift;
  logic [10:0]            frame_full;
  logic                   frame_ok;
  logic [7:0]             rx_byte;
  logic                   break_pending;

  // Bring both PS/2 lines into the clock domain. Clearing to 0 means a line
  // held low across reset release never looks like a falling edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync  <= '0;
      data_sync <= '0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign clk_fall   = clk_sync[SYNC_STAGES-1] & ~clk_sync[SYNC_STAGES-2];
  assign bit_in     = data_sync[SYNC_STAGES-1];
  assign frame_full = {bit_in, shift};
  assign rx_byte    = frame_full[8:1];
  // start=0, stop=1, odd parity over data plus parity bit
  assign frame_ok   = clk_fall && (bit_cnt == 4'd10) && !frame_full[0]
                      && frame_full[10] && (^frame_full[9:1]);

  // Shift in one bit per PS/2 clock fall; counter wraps after the 11th bit
  // whether or not the frame checked out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt <= 4'd0;
      shift   <= '0;
    end else if (clk_fall) begin
      shift   <= {bit_in, shift[9:1]};
      bit_cnt <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
    end
  end

  // Make/break tracking on each valid byte; typematic repeats of the held
  // key and extended prefixes leave everything untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_code     <= 8'h00;
      ascii_code    <= 8'h00;
      press_count   <= 8'h00;
      key_active    <= 1'b0;
      break_pending <= 1'b0;
    end else if (frame_ok) begin
      if (rx_byte == SC_EXT) begin
        // extended prefix carries no key information here
      end else if (rx_byte == SC_BREAK) begin
        break_pending <= 1'b1;
      end else if (break_pending) begin
        break_pending <= 1'b0;
        if (key_active && (rx_byte == scan_code)) key_active <= 1'b0;
      end else if (!key_active || (rx_byte != scan_code)) begin
        scan_code   <= rx_byte;
        ascii_code  <= scan_to_ascii(rx_byte);
        key_active  <= 1'b1;
        press_count <= press_count + 8'd1;
      end
    end
  end

  seg7_hex u_seg1 (.nib(scan_code[3:0]),   .en(key_active), .seg(io_seg1));
  seg7_hex u_seg2 (.nib(scan_code[7:4]),   .en(key_active), .seg(io_seg2));
  seg7_hex u_seg3 (.nib(ascii_code[3:0]),  .en(key_active), .seg(io_seg3));
  seg7_hex u_seg4 (.nib(ascii_code[7:4]),  .en(key_active), .seg(io_seg4));
  seg7_hex u_seg5 (.nib(press_count[3:0]), .en(1'b1),       .seg(io_seg5));
  seg7_hex u_seg6 (.nib(press_count[7:4]), .en(1'b1),       .seg(io_seg6));

endmodule

// File: tb/tb_ps2_key_display.sv
// Scoreboard bench: stimulus pushes hand-computed expected states, a monitor pops and compares.
// Latency: checks are taken several clocks after each frame's stop bit.
// Backpressure: none; the monitor is paced by request counters.
module tb_ps2_key_display;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [6:0] io_seg1, io_seg2, io_seg3, io_seg4, io_seg5, io_seg6;
  logic [7:0] scan_code, ascii_code, press_count;
  logic       key_active;

  ps2_key_display dut (
    .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .io_seg1(io_seg1), .io_seg2(io_seg2), .io_seg3(io_seg3),
    .io_seg4(io_seg4), .io_seg5(io_seg5), .io_seg6(io_seg6),
    .scan_code(scan_code), .ascii_code(ascii_code),
    .press_count(press_count), .key_active(key_active)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] sc;
    logic [7:0] asc;
    logic [7:0] cnt;
    logic       act;
    logic [6:0] s1, s2, s3, s4, s5, s6;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   req_cnt = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: whenever a check is requested, sample away from the edge and
  // compare against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      wait (req_cnt != done_cnt);
      @(negedge clock);
      if (q.size() == 0) begin
        bad++;
        total++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
        e = q.pop_front();
        chk("scan_code",   scan_code,   e.sc);
        chk("ascii_code",  ascii_code,  e.asc);
        chk("press_count", press_count, e.cnt);
        chk("key_active",  key_active,  e.act);
        chk("io_seg1", io_seg1, e.s1);
        chk("io_seg2", io_seg2, e.s2);
        chk("io_seg3", io_seg3, e.s3);
        chk("io_seg4", io_seg4, e.s4);
        chk("io_seg5", io_seg5, e.s5);
        chk("io_seg6", io_seg6, e.s6);
      end
      done_cnt++;
    end
  end

  task automatic expect_state(input logic [7:0] sc, input logic [7:0] asc,
                              input logic [7:0] cnt, input logic act,
                              input logic [6:0] s1, input logic [6:0] s2,
                              input logic [6:0] s3, input logic [6:0] s4,
                              input logic [6:0] s5, input logic [6:0] s6);
    exp_t e;
    e = '{sc: sc, asc: asc, cnt: cnt, act: act,
          s1: s1, s2: s2, s3: s3, s4: s4, s5: s5, s6: s6};
    q.push_back(e);
    req_cnt++;
    #40;
  endtask

  // Drive nbits of a frame; data changes while ps2_clk is high.
  task automatic send_frame(input logic [7:0] b, input logic par_flip,
                            input logic stop_bit, input int nbits);
    logic [10:0] frm;
    frm = {stop_bit, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frm[i];
      #30 ps2_clk = 1'b0;
      #30 ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    #60;
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, 11);
  endtask

  initial begin
    #52 reset = 1'b0;
    #50;
    // reset state
    expect_state(8'h00, 8'h00, 8'h00, 1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40);

    // press, break, release of 'a'
    send(8'h1C);
    expect_state(8'h1C, 8'h61, 8'h01, 1'b1, 7'h46, 7'h79, 7'h79, 7'h02, 7'h79, 7'h40);
    send(8'hF0);
    expect_state(8'h1C, 8'h61, 8'h01, 1'b1, 7'h46, 7'h79, 7'h79, 7'h02, 7'h79, 7'h40);
    send(8'h1C);
    expect_state(8'h1C, 8'h61, 8'h01, 1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40);

    // 's' with typematic repeats counts once
    send(8'h1B);
    expect_state(8'h1B, 8'h73, 8'h02, 1'b1, 7'h03, 7'h79, 7'h30, 7'h78, 7'h24, 7'h40);
    send(8'h1B);
    send(8'h1B);
    expect_state(8'h1B, 8'h73, 8'h02, 1'b1, 7'h03, 7'h79, 7'h30, 7'h78, 7'h24, 7'h40);
    send(8'hE0);
    expect_state(8'h1B, 8'h73, 8'h02, 1'b1, 7'h03, 7'h79, 7'h30, 7'h78, 7'h24, 7'h40);
    send(8'hF0);
    send(8'h1B);
    expect_state(8'h1B, 8'h73, 8'h02, 1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h24, 7'h40);

    // bad parity, then bad stop bit: both dropped
    send_frame(8'h1C, 1'b1, 1'b1, 11);
    expect_state(8'h1B, 8'h73, 8'h02, 1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h24, 7'h40);
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    expect_state(8'h1B, 8'h73, 8'h02, 1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h24, 7'h40);
    send(8'h16);
    expect_state(8'h16, 8'h31, 8'h03, 1'b1, 7'h02, 7'h79, 7'h79, 7'h30, 7'h30, 7'h40);

    // 256 press/release pairs of '0' from a clean count wrap to 00
    reset = 1'b1;
    #30 reset = 1'b0;
    #50;
    for (int i = 0; i < 256; i++) begin
      send(8'h45);
      if (i == 0)
        expect_state(8'h45, 8'h30, 8'h01, 1'b1, 7'h12, 7'h19, 7'h40, 7'h30, 7'h79, 7'h40);
      if (i == 255)
        expect_state(8'h45, 8'h30, 8'h00, 1'b1, 7'h12, 7'h19, 7'h40, 7'h30, 7'h40, 7'h40);
      send(8'hF0);
      send(8'h45);
    end
    expect_state(8'h45, 8'h30, 8'h00, 1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40);
    send(8'h76);
    expect_state(8'h76, 8'h00, 8'h01, 1'b1, 7'h02, 7'h78, 7'h40, 7'h40, 7'h79, 7'h40);

    // reset after 5 bits of a frame, then a clean frame
    send_frame(8'h5A, 1'b0, 1'b1, 5);
    reset = 1'b1;
    #30 reset = 1'b0;
    #50;
    expect_state(8'h00, 8'h00, 8'h00, 1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40);
    send(8'h29);
    expect_state(8'h29, 8'h20, 8'h01, 1'b1, 7'h10, 7'h24, 7'h40, 7'h24, 7'h79, 7'h40);

    // let the monitor drain, bounded
    for (int k = 0; k < 100 && done_cnt != req_cnt; k++) @(posedge clock);
    if (done_cnt != req_cnt) begin
      bad++;
      total++;
      $display("FAIL monitor_drain: got %0d checks expected %0d", done_cnt, req_cnt);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
